// File: rtl/pixel_store_pkg.sv
// pixel_store_pkg: shared constants and types for the pixel_store write path.
//   NUM_ADDRS - number of frame-buffer words in one frame
//   ADDR_W    - default frame-buffer address width
//   channel_e - one-hot colour channel turn marker (R -> G -> B -> R)
package pixel_store_pkg;

    localparam int unsigned NUM_ADDRS = 115200;
    localparam int unsigned ADDR_W    = 17;

    typedef enum logic [2:0] {
        CH_R = 3'b001,
        CH_G = 3'b010,
        CH_B = 3'b100
    } channel_e;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with an occupancy counter; all DEPTH entries usable.
//   clk, rst     - clock, synchronous active-high reset (empties the FIFO)
//   push, din    - write request and data; ignored while full
//   pop, dout    - read request and head word; pop ignored while empty
//   full, empty  - occupancy flags derived from level
//   level        - current number of stored words (one bit wider than the pointers)
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    assign full  = (level == (PW + 1)'(DEPTH));
    assign empty = (level == '0);

    // Head is read straight out of the register array, so dout never depends on din.
    assign dout = storage[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) storage[wr_ptr] <= din;
    end

endmodule

// File: rtl/pixel_store.sv
// pixel_store: collects R, G, B words in strict rotation and writes them to frame
// memory at a sequential address that wraps once per frame.
//   clk, rst              - clock, synchronous active-high reset
//   in_data               - word shared by the three colour producers
//   r/g/b_rts, r/g/b_rtr  - per-channel handshake; only the channel whose turn it is
//                           sees rtr, out-of-turn producers simply wait
//   mem_data, mem_addr    - FIFO head and frame address of the pending write
//   mem_rts, mem_rtr      - memory write handshake
//   frame_done            - one-cycle pulse after the last address of a frame is written
//   level                 - FIFO occupancy
module pixel_store #(
    parameter int unsigned NUM_ADDRS = pixel_store_pkg::NUM_ADDRS,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned AW        = pixel_store_pkg::ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            in_data,
    input  logic                   r_rts,
    output logic                   r_rtr,
    input  logic                   g_rts,
    output logic                   g_rtr,
    input  logic                   b_rts,
    output logic                   b_rtr,
    output logic [31:0]            mem_data,
    output logic [AW-1:0]          mem_addr,
    output logic                   mem_rts,
    input  logic                   mem_rtr,
    output logic                   frame_done,
    output logic [$clog2(DEPTH):0] level
);

    import pixel_store_pkg::*;

    localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_ADDRS - 1);

    channel_e      state;
    logic          full;
    logic          empty;
    logic          can_take;
    logic          r_xfc;
    logic          g_xfc;
    logic          b_xfc;
    logic          push;
    logic          mem_xfc;
    logic [AW-1:0] wr_ptr;

    // Ready depends only on registered state, the FIFO level and reset: no rts -> rtr path.
    assign can_take = ~full & ~rst;
    assign r_rtr    = (state == CH_R) & can_take;
    assign g_rtr    = (state == CH_G) & can_take;
    assign b_rtr    = (state == CH_B) & can_take;

    assign r_xfc = r_rts & r_rtr;
    assign g_xfc = g_rts & g_rtr;
    assign b_xfc = b_rts & b_rtr;
    assign push  = r_xfc | g_xfc | b_xfc;

    assign mem_rts  = ~empty;
    assign mem_xfc  = mem_rts & mem_rtr;
    assign mem_addr = wr_ptr;

    // Channel rotation: at most one xfc can fire since only one rtr is ever high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CH_R;
        end else if (r_xfc) begin
            state <= CH_G;
        end else if (g_xfc) begin
            state <= CH_B;
        end else if (b_xfc) begin
            state <= CH_R;
        end
    end

    // Write address advances only on an accepted write, so it holds during a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= mem_xfc & (wr_ptr == LAST_ADDR);
            if (mem_xfc) begin
                wr_ptr <= (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (mem_xfc),
        .din   (in_data),
        .dout  (mem_data),
        .full  (full),
        .empty (empty),
        .level (level)
    );

endmodule

// File: tb/tb_pixel_store.sv
// Scoreboard bench for pixel_store. A small frame size keeps wrap-around reachable
// in a short run; the rotation/FIFO/address rules are frame-size independent.
module tb_pixel_store;

    localparam int unsigned N     = 48;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 17;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [31:0]            in_data;
    logic                   r_rts, g_rts, b_rts;
    logic                   r_rtr, g_rtr, b_rtr;
    logic [31:0]            mem_data;
    logic [AW-1:0]          mem_addr;
    logic                   mem_rts;
    logic                   mem_rtr;
    logic                   frame_done;
    logic [$clog2(DEPTH):0] level;

    always #5 clk = ~clk;

    pixel_store #(
        .NUM_ADDRS (N),
        .DEPTH     (DEPTH),
        .AW        (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .r_rts      (r_rts),
        .r_rtr      (r_rtr),
        .g_rts      (g_rts),
        .g_rtr      (g_rtr),
        .b_rts      (b_rts),
        .b_rtr      (b_rtr),
        .mem_data   (mem_data),
        .mem_addr   (mem_addr),
        .mem_rts    (mem_rts),
        .mem_rtr    (mem_rtr),
        .frame_done (frame_done),
        .level      (level)
    );

    int unsigned compared   = 0;
    int unsigned mismatched = 0;

    // Words the model says were accepted and not yet written, oldest first.
    logic [31:0] exp_q[$];

    // Reference model state: words held and whose turn it is (0=R, 1=G, 2=B).
    int unsigned mlevel = 0;
    int unsigned turn   = 0;
    bit          started = 1'b0;

    // Monitor state.
    int unsigned   exp_addr = 0;
    bit            fd_exp = 1'b0;
    bit            stall_prev = 1'b0;
    logic [31:0]   held_data;
    logic [AW-1:0] held_addr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus: drive, check the handshake-side view, update the model.
    task automatic cycle(input logic [2:0] rts, input logic rr, input logic rs,
                         input logic [31:0] d);
        logic [2:0] exp_rtr;
        bit         accept;
        bit         popm;
        rst     = rs;
        {b_rts, g_rts, r_rts} = rts;
        mem_rtr = rr;
        in_data = d;
        #1;
        exp_rtr = (rs || mlevel >= DEPTH) ? 3'b000 : 3'(1 << turn);
        chk("rtr", 64'({b_rtr, g_rtr, r_rtr}), 64'(exp_rtr));
        chk("mem_rts", 64'(mem_rts), 64'(mlevel != 0));
        chk("level", 64'(level), 64'(mlevel));
        accept = !rs && mlevel < DEPTH && rts[turn];
        popm   = !rs && mlevel > 0 && rr;
        if (accept) begin
            exp_q.push_back(d);
            turn = (turn + 1) % 3;
        end
        mlevel = mlevel + (accept ? 1 : 0) - (popm ? 1 : 0);
        if (rs) begin
            mlevel = 0;
            turn   = 0;
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: sampled mid-cycle; a write seen now completes at the next edge.
    always @(negedge clk) begin
        if (started) begin
            chk("frame_done", 64'(frame_done), 64'(fd_exp));
            if (rst) begin
                exp_q.delete();
                exp_addr   = 0;
                fd_exp     = 1'b0;
                stall_prev = 1'b0;
            end else begin
                if (stall_prev && mem_rts) begin
                    chk("hold_data", 64'(mem_data), 64'(held_data));
                    chk("hold_addr", 64'(mem_addr), 64'(held_addr));
                end
                fd_exp = 1'b0;
                if (mem_rts && mem_rtr) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_write", 64'(mem_rts), 64'(0));
                    end else begin
                        chk("mem_data", 64'(mem_data), 64'(exp_q.pop_front()));
                        chk("mem_addr", 64'(mem_addr), 64'(exp_addr));
                        fd_exp   = (exp_addr == N - 1);
                        exp_addr = fd_exp ? 0 : exp_addr + 1;
                    end
                end
                stall_prev = mem_rts && !mem_rtr;
                held_data  = mem_data;
                held_addr  = mem_addr;
            end
        end
    end

    initial begin
        rst     = 1'b1;
        {b_rts, g_rts, r_rts} = 3'b000;
        mem_rtr = 1'b0;
        in_data = '0;
        @(posedge clk);
        #1;
        started = 1'b1;

        // Reset state.
        repeat (2) cycle(3'b111, 1'b1, 1'b1, $urandom);

        // Basic rotation with fixed words.
        cycle(3'b111, 1'b1, 1'b0, 32'h11);
        cycle(3'b111, 1'b1, 1'b0, 32'h22);
        cycle(3'b111, 1'b1, 1'b0, 32'h33);
        repeat (4) cycle(3'b000, 1'b1, 1'b0, $urandom);

        // Out-of-turn producers stall until R shows up.
        repeat (10) cycle(3'b110, 1'b1, 1'b0, $urandom);
        repeat (3) cycle(3'b111, 1'b1, 1'b0, $urandom);
        repeat (4) cycle(3'b000, 1'b1, 1'b0, $urandom);

        // Backpressure up to full, then release with producers still pushing.
        repeat (12) cycle(3'b111, 1'b0, 1'b0, $urandom);
        chk("full_level", 64'(level), 64'(DEPTH));
        repeat (20) cycle(3'b111, 1'b1, 1'b0, $urandom);
        repeat (10) cycle(3'b000, 1'b1, 1'b0, $urandom);

        // Mid-stream reset with words buffered and G's turn pending.
        repeat (4) cycle(3'b111, 1'b0, 1'b0, $urandom);
        cycle(3'b111, 1'b1, 1'b1, $urandom);
        chk("post_reset_level", 64'(level), 64'(0));
        repeat (6) cycle(3'b111, 1'b1, 1'b0, $urandom);

        // Stream past two frame boundaries.
        repeat (2 * N + 10) cycle(3'b111, 1'b1, 1'b0, $urandom);

        // Random traffic with occasional resets.
        repeat (3000) begin
            cycle(3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 149) == 0), $urandom);
        end

        // Drain.
        repeat (20) cycle(3'b000, 1'b1, 1'b0, $urandom);
        chk("drain_queue", 64'(exp_q.size()), 64'(0));
        chk("drain_level", 64'(level), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pixel_store.md
Name: pixel_store

Overview:
- Write-side counterpart of the frame-buffer read path.
- Collects 32-bit words from three colour-channel producers (R, G, B), each with an rts/rtr handshake, in strict R->G->B rotation.
- Buffers the words in a small FIFO and writes them to frame memory at a sequential, wrapping address.
- Sits between the colour processing stages and the frame-buffer memory write port.

Parameters:
- NUM_ADDRS, 115200, number of frame-buffer words; the write pointer wraps at NUM_ADDRS-1.
- DEPTH, 8, FIFO depth in words; must be a power of 2, >= 2.
- AW, 17, memory address width; must satisfy 2^AW >= NUM_ADDRS.

Ports:
- clk  in  1  system clock, all logic on posedge
- rst  in  1  synchronous reset, active-high
- in_data  in  32  channel data, shared by R/G/B producers
- r_rts  in  1  R producer has data
- r_rtr  out  1  pixel_store accepts R word
- g_rts  in  1  G producer has data
- g_rtr  out  1  pixel_store accepts G word
- b_rts  in  1  B producer has data
- b_rtr  out  1  pixel_store accepts B word
- mem_data  out  32  word to write
- mem_addr  out  AW  write address
- mem_rts  out  1  write request valid
- mem_rtr  in  1  memory accepts write
- frame_done  out  1  one-cycle pulse when the word at NUM_ADDRS-1 is written
- level  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Transfer rule: any xfc = rts & rtr on the same clk edge. No combinational path from any rts to any rtr.
- Channel state: one-hot {B,G,R}, reset to 3'b001 (R).
  - On r_xfc go to 010; on g_xfc go to 100; on b_xfc go to 001.
  - At most one channel rtr is high per cycle, so at most one channel xfc occurs.
- Input ready:
  - r_rtr = state[0] & ~full & ~rst
  - g_rtr = state[1] & ~full & ~rst
  - b_rtr = state[2] & ~full & ~rst
  - A producer asserting rts out of turn is simply stalled; nothing is dropped and there is no error.
- FIFO:
  - Push in_data on any channel xfc. Pop on mem_xfc = mem_rts & mem_rtr.
  - Occupancy counter gives full = (level == DEPTH) and empty = (level == 0). All DEPTH entries are usable.
  - Simultaneous push and pop: level unchanged, both pointers advance. This is legal even when full, because full gates rtr in the same cycle.
- Output:
  - mem_rts = ~empty. mem_data is the FIFO head, registered read; no combinational path from in_data.
  - mem_addr = wr_ptr register.
  - On mem_xfc: wr_ptr <= (wr_ptr == NUM_ADDRS-1) ? 0 : wr_ptr+1.
  - mem_data and mem_addr must hold stable while mem_rts=1 and mem_rtr=0.
- frame_done: registered; high for exactly the cycle after the mem_xfc whose mem_addr was NUM_ADDRS-1.
- Latency: an input word accepted at edge N gives mem_rts=1 after edge N, i.e. in cycle N+1 when the FIFO was empty.
- Reset (synchronous, any time including mid-frame or mid-stall):
  - state=001, wr_ptr=0, FIFO empty, level=0, frame_done=0, mem_rts=0.
  - All rtr low during the reset cycle.
  - Buffered words are discarded; the first word after reset is written to address 0 and must be R.
- Width rules: pointers wrap modulo DEPTH naturally; level is one bit wider than the pointers. wr_ptr never reaches a value >= NUM_ADDRS.

Decomposition:
- Shared package:
  - NUM_ADDRS (115200)
  - channel one-hot constants CH_R=3'b001, CH_G=3'b010, CH_B=3'b100
  - default address width 17
- Sub-module sync_fifo (parameters WIDTH, DEPTH; ports push, pop, din, dout, full, empty, level, sync active-high rst). pixel_store instantiates it once.
- Channel sequencer and address counter stay in the top module.

Test Plan:
- Basic order: all rts=1, mem_rtr=1, words R=0x11, G=0x22, B=0x33 -> memory writes (0,0x11), (1,0x22), (2,0x33); state returns to 001.
- Out-of-order stall: g_rts=1 and b_rts=1, r_rts=0 for 10 cycles -> g_rtr=b_rtr=0, no push, level=0; then r_rts=1 -> R accepted first, then G.
- Backpressure/full: mem_rtr=0, feed 8 words -> level=8, all rtr=0, mem_data/mem_addr stable; then mem_rtr=1 -> 8 writes to addr 0..7 in order, no loss.
- Simultaneous push/pop at full: level=8, mem_rtr=1, channel rts=1 -> the next cycle pops one word and, since rtr was 0, pushes none; steady streaming afterwards holds level constant.
- Wrap: preset by streaming 115200 words -> last write at addr 115199, frame_done=1 for one cycle, next write at addr 0.
- Mid-stream reset: rst=1 for 1 cycle with level=5 and state=010 -> level=0, mem_rts=0, state=001, next write goes to addr 0 with an R word.
